// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shared barrel shifter and its arbiter.
//   SHIFT_W  : data width of the shifter (32)
//   SA_W     : shift amount width (5)
//   src_t    : requester / source identifier, also used by the writeback mux
//              SRC_ALU = ALU execute path, SRC_MEM = load/store alignment path
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int SHIFT_W = 32;
    localparam int SA_W    = 5;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_t;

    // The requester that did not win last time; used to break ties.
    function automatic src_t other_src(input src_t s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/SHIFTX32.sv
// -----------------------------------------------------------------------------
// SHIFTX32
// Purely combinational 32-bit barrel shifter.
//   X        in  32  operand
//   Sa       in  5   shift amount 0..31 (0 passes X through)
//   IsArith  in  1   arithmetic right select (ignored for left shifts)
//   IsRight  in  1   1 = right, 0 = left
//   Y        out 32  shifted result
// -----------------------------------------------------------------------------
module SHIFTX32
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] X,
    input  logic [SA_W-1:0]    Sa,
    input  logic               IsArith,
    input  logic               IsRight,
    output logic [SHIFT_W-1:0] Y
);

    logic [SHIFT_W-1:0] y_s;

    // Select shift flavour from direction and arithmetic flag.
    always_comb begin
        y_s = X;
        case ({IsRight, IsArith})
            2'b00:   y_s = X << Sa;
            2'b01:   y_s = X << Sa;
            2'b10:   y_s = X >> Sa;
            2'b11:   y_s = SHIFT_W'($signed(X) >>> Sa);
            default: y_s = X;
        endcase
    end

    assign Y = y_s;

endmodule

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
// Shares one SHIFTX32 between the ALU path (requester 0) and the load/store
// alignment path (requester 1). A two-state round-robin arbiter grants at most
// one request per cycle into a single registered result slot.
//   Clk                       in  1   rising-edge clock
//   ResetN                    in  1   asynchronous active-low reset
//   InValid                   in  2   per-requester valid
//   InReady                   out 2   per-requester ready (combinational, one-hot or zero)
//   InX0/InX1                 in  32  operands
//   InSa0/InSa1               in  5   shift amounts
//   InIsArith0/InIsArith1     in  1   arithmetic-right select
//   InIsRight0/InIsRight1     in  1   direction (1 = right)
//   OutValid                  out 1   result slot holds an unconsumed result
//   OutReady                  in  1   consumer accepts the result
//   OutY                      out 32  shifted result
//   OutSrc                    out 1   requester that produced OutY
//   Busy                      out 1   OutValid or any InValid
// -----------------------------------------------------------------------------
module shift_arbiter
    import shift_pkg::*;
(
    input  logic               Clk,
    input  logic               ResetN,
    input  logic [1:0]         InValid,
    output logic [1:0]         InReady,
    input  logic [SHIFT_W-1:0] InX0,
    input  logic [SHIFT_W-1:0] InX1,
    input  logic [SA_W-1:0]    InSa0,
    input  logic [SA_W-1:0]    InSa1,
    input  logic               InIsArith0,
    input  logic               InIsArith1,
    input  logic               InIsRight0,
    input  logic               InIsRight1,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [SHIFT_W-1:0] OutY,
    output logic               OutSrc,
    output logic               Busy
);

    logic               out_valid_r;
    logic [SHIFT_W-1:0] out_y_r;
    src_t               out_src_r;
    src_t               last_grant_r;

    logic               slot_free_s;
    logic [1:0]         ready_s;
    logic               accept_s;
    src_t               sel_s;

    logic [SHIFT_W-1:0] mux_x_s;
    logic [SA_W-1:0]    mux_sa_s;
    logic               mux_arith_s;
    logic               mux_right_s;
    logic [SHIFT_W-1:0] shift_y_s;

    // A slot refills in the same cycle it drains.
    assign slot_free_s = ~out_valid_r | OutReady;

    // Grant decision: depends only on handshake state, never on operand data.
    // ResetN gates the grant so nothing is accepted while reset is asserted.
    always_comb begin
        ready_s = 2'b00;
        sel_s   = SRC_ALU;
        if (ResetN && slot_free_s) begin
            case (InValid)
                2'b01: begin
                    ready_s = 2'b01;
                    sel_s   = SRC_ALU;
                end
                2'b10: begin
                    ready_s = 2'b10;
                    sel_s   = SRC_MEM;
                end
                2'b11: begin
                    sel_s   = other_src(last_grant_r);
                    ready_s = (sel_s == SRC_MEM) ? 2'b10 : 2'b01;
                end
                default: begin
                    ready_s = 2'b00;
                    sel_s   = SRC_ALU;
                end
            endcase
        end else begin
            ready_s = 2'b00;
            sel_s   = SRC_ALU;
        end
    end

    assign accept_s = |ready_s;

    // Route the granted requester's operands into the shared shifter.
    always_comb begin
        mux_x_s     = InX0;
        mux_sa_s    = InSa0;
        mux_arith_s = InIsArith0;
        mux_right_s = InIsRight0;
        if (sel_s == SRC_MEM) begin
            mux_x_s     = InX1;
            mux_sa_s    = InSa1;
            mux_arith_s = InIsArith1;
            mux_right_s = InIsRight1;
        end else begin
            mux_x_s     = InX0;
            mux_sa_s    = InSa0;
            mux_arith_s = InIsArith0;
            mux_right_s = InIsRight0;
        end
    end

    SHIFTX32 u_shifter (
        .X       (mux_x_s),
        .Sa      (mux_sa_s),
        .IsArith (mux_arith_s),
        .IsRight (mux_right_s),
        .Y       (shift_y_s)
    );

    // Result slot and round-robin pointer; LastGrant resets to MEM so ALU wins the first tie.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            out_valid_r  <= 1'b0;
            out_y_r      <= 32'h0000_0000;
            out_src_r    <= SRC_ALU;
            last_grant_r <= SRC_MEM;
        end else if (accept_s) begin
            out_valid_r  <= 1'b1;
            out_y_r      <= shift_y_s;
            out_src_r    <= sel_s;
            last_grant_r <= sel_s;
        end else if (OutReady) begin
            out_valid_r  <= 1'b0;
        end
    end

    assign InReady  = ready_s;
    assign OutValid = out_valid_r;
    assign OutY     = out_y_r;
    assign OutSrc   = out_src_r;
    assign Busy     = out_valid_r | (|InValid);

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic [1:0]  InValid;
    logic [1:0]  InReady;
    logic [31:0] InX0, InX1;
    logic [4:0]  InSa0, InSa1;
    logic        InIsArith0, InIsArith1, InIsRight0, InIsRight1;
    logic        OutValid, OutReady, OutSrc, Busy;
    logic [31:0] OutY;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    shift_arbiter dut (
        .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .InX0(InX0), .InX1(InX1), .InSa0(InSa0), .InSa1(InSa1),
        .InIsArith0(InIsArith0), .InIsArith1(InIsArith1),
        .InIsRight0(InIsRight0), .InIsRight1(InIsRight1),
        .OutValid(OutValid), .OutReady(OutReady), .OutY(OutY),
        .OutSrc(OutSrc), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid;
    logic [31:0] m_y;
    logic        m_src;
    logic        m_last;

    function automatic logic [31:0] shift_ref(input logic [31:0] x, input int sa,
                                              input logic arith, input logic right);
        logic [31:0] ones;
        if (!right) return x << sa;
        if (arith && x[31]) begin
            ones = ~x;
            return ~(ones >> sa);
        end
        return x >> sa;
    endfunction

    function automatic logic [1:0] exp_ready();
        if (ResetN !== 1'b1) return 2'b00;
        if (m_valid && !OutReady) return 2'b00;
        if (InValid == 2'b11) return (m_last == 1'b1) ? 2'b01 : 2'b10;
        return InValid;
    endfunction

    always @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            m_valid <= 1'b0;
            m_y     <= 32'h0;
            m_src   <= 1'b0;
            m_last  <= 1'b1;
        end else begin
            if (exp_ready() == 2'b01) begin
                m_valid <= 1'b1;
                m_src   <= 1'b0;
                m_last  <= 1'b0;
                m_y     <= shift_ref(InX0, int'(InSa0), InIsArith0, InIsRight0);
            end else if (exp_ready() == 2'b10) begin
                m_valid <= 1'b1;
                m_src   <= 1'b1;
                m_last  <= 1'b1;
                m_y     <= shift_ref(InX1, int'(InSa1), InIsArith1, InIsRight1);
            end else if (OutReady) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("cyc_InReady",  {30'd0, InReady},  {30'd0, exp_ready()});
            chk("cyc_OutValid", {31'd0, OutValid}, {31'd0, m_valid});
            chk("cyc_OutY",     OutY,              m_y);
            chk("cyc_OutSrc",   {31'd0, OutSrc},   {31'd0, m_src});
            chk("cyc_Busy",     {31'd0, Busy},     {31'd0, m_valid | (|InValid)});
        end
    end

    task automatic edge1();
        @(posedge Clk);
        #1;
    endtask

    task automatic set0(input logic [31:0] x, input logic [4:0] sa, input logic a, input logic r);
        InX0 = x; InSa0 = sa; InIsArith0 = a; InIsRight0 = r;
    endtask

    task automatic set1(input logic [31:0] x, input logic [4:0] sa, input logic a, input logic r);
        InX1 = x; InSa1 = sa; InIsArith1 = a; InIsRight1 = r;
    endtask

    task automatic do_reset();
        ResetN  = 1'b0;
        InValid = 2'b00;
        edge1();
        ResetN = 1'b1;
    endtask

    logic [1:0]  rdy;
    logic [31:0] y_hold;
    logic        s_hold;
    logic [1:0]  srcs [4];
    int          cnt0, cnt1;

    initial begin
        ResetN = 1'b0; OutReady = 1'b0; InValid = 2'b11;
        set0(32'h0, 5'd0, 1'b0, 1'b0);
        set1(32'h0, 5'd0, 1'b0, 1'b0);

        // model pinning
        chk("ref_arith",  shift_ref(32'h8000_0000, 4, 1'b1, 1'b1), 32'hF800_0000);
        chk("ref_logic",  shift_ref(32'h8000_0000, 4, 1'b0, 1'b1), 32'h0800_0000);
        chk("ref_left",   shift_ref(32'h0000_0001, 1, 1'b0, 1'b0), 32'h0000_0002);
        chk("ref_sa31",   shift_ref(32'h8000_0000, 31, 1'b1, 1'b1), 32'hFFFF_FFFF);

        // reset state while requests are present
        #3;
        chk("rst_InReady",  {30'd0, InReady},  32'd0);
        chk("rst_OutValid", {31'd0, OutValid}, 32'd0);
        chk("rst_OutY",     OutY,              32'h0);
        chk("rst_OutSrc",   {31'd0, OutSrc},   32'd0);
        InValid = 2'b00;
        edge1();
        ResetN = 1'b1;
        chk_en = 1'b1;

        // requester 0 alone
        OutReady = 1'b1;
        set0(32'h0000_0001, 5'd1, 1'b0, 1'b0);
        InValid = 2'b01;
        @(negedge Clk);
        chk("t1_InReady", {30'd0, InReady}, 32'd1);
        edge1();
        InValid = 2'b00;
        chk("t1_OutY",   OutY,              32'h0000_0002);
        chk("t1_OutSrc", {31'd0, OutSrc},   32'd0);

        // requester 1 alone, arithmetic then logical right
        set1(32'h8000_0000, 5'd4, 1'b1, 1'b1);
        InValid = 2'b10;
        edge1();
        chk("t2_OutY_arith", OutY,            32'hF800_0000);
        chk("t2_OutSrc",     {31'd0, OutSrc}, 32'd1);
        InIsArith1 = 1'b0;
        edge1();
        chk("t2_OutY_logic", OutY,            32'h0800_0000);
        InValid = 2'b00;
        edge1();

        // fairness after reset
        do_reset();
        set0(32'h0000_00F0, 5'd4, 1'b0, 1'b0);
        set1(32'hF000_0000, 5'd8, 1'b1, 1'b1);
        InValid = 2'b11;
        OutReady = 1'b1;
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 4; k++) begin
            edge1();
            srcs[k] = {1'b0, OutSrc};
            if (OutSrc) cnt1++; else cnt0++;
        end
        chk("fair_seq", {24'd0, srcs[0], srcs[1], srcs[2], srcs[3]}, 32'b00_01_00_01);
        chk("fair_cnt0", cnt0, 32'd2);
        chk("fair_cnt1", cnt1, 32'd2);
        chk("fair_y", OutY, 32'hFFF0_0000);

        // backpressure with both requesters pending
        OutReady = 1'b0;
        y_hold = OutY;
        s_hold = OutSrc;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("hold_InReady", {30'd0, InReady}, 32'd0);
            edge1();
            chk("hold_OutY",   OutY,            y_hold);
            chk("hold_OutSrc", {31'd0, OutSrc}, {31'd0, s_hold});
        end
        OutReady = 1'b1;
        @(negedge Clk);
        chk("drain_InReady", {30'd0, InReady}, 32'd1);
        edge1();
        chk("drain_OutValid", {31'd0, OutValid}, 32'd1);
        chk("drain_OutSrc",   {31'd0, OutSrc},   32'd0);
        chk("drain_OutY",     OutY,              32'h0000_0F00);

        // asynchronous reset mid-cycle with a result pending
        #2;
        ResetN = 1'b0;
        #1;
        chk("arst_OutValid", {31'd0, OutValid}, 32'd0);
        chk("arst_InReady",  {30'd0, InReady},  32'd0);
        edge1();
        ResetN = 1'b1;
        @(negedge Clk);
        chk("arst_tie_InReady", {30'd0, InReady}, 32'd1);
        edge1();
        chk("arst_tie_OutSrc", {31'd0, OutSrc}, 32'd0);
        InValid = 2'b00;

        // zero shift passes data through for every mode
        for (int m = 0; m < 4; m++) begin
            set0(32'hDEAD_BEEF, 5'd0, m[0], m[1]);
            InValid = 2'b01;
            edge1();
            chk("sa0_OutY", OutY, 32'hDEAD_BEEF);
        end
        InValid = 2'b00;
        edge1();

        // randomized phase; operands held while a request waits
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            rdy = InReady;
            edge1();
            OutReady = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                if (InValid[i] && !rdy[i]) begin
                    if ($urandom_range(0, 7) == 0) InValid[i] = 1'b0;
                end else begin
                    InValid[i] = ($urandom_range(0, 2) != 0);
                    if (i == 0)
                        set0($urandom(), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    else
                        set1($urandom(), ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31)),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
        end
        @(negedge Clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 32-bit barrel shifter (`SHIFTX32`) between two requesters: requester 0 is the ALU execute path and requester 1 is the load/store byte-alignment path. A round-robin arbiter grants at most one request per cycle, and the result is captured in a single output register. Each requester sees a valid/ready handshake, and the consumer sees a registered result tagged with its source. The block sits between the decode/execute stage and the writeback mux, replacing the per-path shifters.

## Interface
- No parameters. Data width is fixed at 32 and shift amount at 5.
- Clk  in  1  system clock; all state updates on the rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- InValid  in  2  per-requester request valid; bit i belongs to requester i.
- InReady  out  2  per-requester ready; combinational, one-hot or zero.
- InX0, InX1  in  32  operand for requester 0 and requester 1.
- InSa0, InSa1  in  5  shift amount, 0..31.
- InIsArith0, InIsArith1  in  1  arithmetic-right select.
- InIsRight0, InIsRight1  in  1  direction: 1 = right, 0 = left.
- OutValid  out  1  result register holds an unconsumed result.
- OutReady  in  1  consumer accepts the result this cycle.
- OutY  out  32  shifted result.
- OutSrc  out  1  index of the requester that produced OutY.
- Busy  out  1  OutValid OR any InValid bit set.

## Operation
- Shift semantics:
  - IsRight=0: logical left; IsArith is ignored.
  - IsRight=1, IsArith=0: logical right.
  - IsRight=1, IsArith=1: arithmetic right, replicating X[31].
  - Sa=0 passes X unchanged.
- Slot free when OutValid=0 or OutReady=1 (same-cycle drain and refill is allowed).
- Grant rules, applied only when the slot is free:
  - Exactly one InValid bit set: grant that requester.
  - Both InValid bits set: grant the requester whose index differs from LastGrant.
  - Slot not free: InReady = 2'b00.
- Accept: InValid[i] & InReady[i]. On accept, the mux selects that requester's operands into `SHIFTX32`. OutY, OutSrc and OutValid=1 load at the next edge, and LastGrant is set to i.
- Drain: OutValid & OutReady with no accept in the same cycle clears OutValid.
- Hold: OutValid & ~OutReady keeps OutY and OutSrc stable and blocks all grants.
- Requesters must hold their operands stable while InValid=1 and InReady=0. Dropping InValid before acceptance is allowed and discards the request.
- Two-state arbiter: LastGrant ∈ {0, 1}.

## Timing
- Reset (ResetN=0, asynchronous):
  - OutValid=0, OutY=32'h0, OutSrc=0.
  - LastGrant=1, so requester 0 wins the first tie.
  - InReady follows the combinational rules: 2'b00 while ResetN=0.
- Latency: accept at edge N gives OutValid=1 with the result visible after edge N.
- Throughput: one result per cycle while OutReady=1.
- Fairness: with both requesters continuously valid and OutReady=1, grants alternate 0,1,0,1 starting with 0.
- Reset mid-operation: a pending OutValid is dropped immediately. No request is accepted while ResetN=0.
- InReady depends on InValid, OutValid, OutReady and LastGrant only; it has no path from the data inputs.

## Structure
- Shared package shift_pkg holds:
  - SHIFT_W=32 and SA_W=5.
  - Source IDs SRC_ALU=0 and SRC_MEM=1, also used by the writeback mux.
- One sub-module: the existing `SHIFTX32`, instantiated once and fed from the grant mux.
- The arbiter and output register stay inline. The RTL estimate is about 150 lines.

## Test plan
- Reset, then requester 0 only, X=32'h00000001, Sa=1, left, OutReady=1: InReady=2'b01 in the same cycle; next cycle OutY=32'h00000002, OutSrc=0.
- Requester 1 only, X=32'h80000000, Sa=4, IsArith=1, IsRight=1: OutY=32'hF8000000, OutSrc=1. Same stimulus with IsArith=0: OutY=32'h08000000.
- Both valid for 4 cycles after reset with OutReady=1: OutSrc sequence is 0,1,0,1 and each requester sees exactly 2 accepts.
- OutReady=0 for 3 cycles with a result pending and both requesters valid: InReady=2'b00, and OutY and OutSrc are unchanged. On OutReady=1, the result drains and a new grant is accepted in the same cycle.
- ResetN pulsed low while OutValid=1: OutValid=0 asynchronously. After release, a tie goes to requester 0.
- Sa=0, X=32'hDEADBEEF, all four IsArith/IsRight combinations: OutY=32'hDEADBEEF in every case.
